// File: rtl/irq_source_controller_if.sv
// IRQ handshake between the interrupt source controller (master) and the core (slave).
interface irq_source_controller_if;
   logic        irq_req_o;
   logic [31:0] irq_addr_o;
   logic        irq_grant_i;
   logic        irq_done_i;

   modport master (output irq_req_o, irq_addr_o, input irq_grant_i, irq_done_i);
   modport slave  (input irq_req_o, irq_addr_o, output irq_grant_i, irq_done_i);
endinterface

// File: rtl/irq_source_controller.sv
// Edge-detected, masked, fixed-priority interrupt source controller.
// Presents one vectored request at a time to the core and tracks it to completion.
module irq_source_controller #(
   parameter int unsigned NUM_SRC       = 8,
   parameter logic [31:0] VEC_BASE_RST  = 32'h0000_0100,
   parameter int unsigned GRANT_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        irq_src_i,
   irq_source_controller_if.master   irq,
   input  logic                      cfg_we,
   input  logic [1:0]                cfg_addr,
   input  logic [31:0]               cfg_wdata,
   output logic [31:0]               cfg_rdata,
   output logic                      busy_o
);

   localparam int unsigned CNT_W = $clog2(GRANT_TIMEOUT);
   localparam int unsigned ID_W  = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] src_prev;
   logic [ID_W-1:0]    active_id;
   logic               timeout_flag;
   logic [31:0]        vec_base;
   logic [CNT_W-1:0]   counter;

   logic [NUM_SRC-1:0] edge_set;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] pend_clr;
   logic [NUM_SRC-1:0] pending_next;
   logic [ID_W-1:0]    winner;
   logic               grant_take;

   // Pending update: W1C and grant clears, new edges win over clears.
   always_comb begin
      edge_set   = irq_src_i & ~src_prev;
      eligible   = pending & mask;
      grant_take = (state == REQ) && irq.irq_grant_i;
      pend_clr   = '0;
      if (cfg_we && (cfg_addr == 2'd1))
         pend_clr = cfg_wdata[NUM_SRC-1:0];
      if (grant_take)
         pend_clr = pend_clr | (NUM_SRC'(1) << active_id);
      pending_next = (pending & ~pend_clr) | edge_set;
   end

   // Fixed priority: lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i])
            winner = ID_W'(i);
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd0:    cfg_rdata = 32'(mask);
         2'd1:    cfg_rdata = 32'(pending);
         2'd2:    cfg_rdata = {state, 21'b0, timeout_flag, 3'b0, active_id};
         default: cfg_rdata = vec_base;
      endcase
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         mask           <= '0;
         pending        <= '0;
         src_prev       <= '0;
         active_id      <= '0;
         timeout_flag   <= 1'b0;
         vec_base       <= VEC_BASE_RST;
         counter        <= '0;
         irq.irq_req_o  <= 1'b0;
         irq.irq_addr_o <= '0;
      end else begin
         src_prev <= irq_src_i;
         pending  <= pending_next;

         if (cfg_we) begin
            case (cfg_addr)
               2'd0:    mask <= cfg_wdata[NUM_SRC-1:0];
               2'd2:    if (cfg_wdata[8]) timeout_flag <= 1'b0;
               2'd3:    vec_base <= {cfg_wdata[31:2], 2'b00};
               default: ;
            endcase
         end

         // A timeout in the same cycle as a STATUS clear leaves the flag set.
         case (state)
            IDLE: begin
               if (|eligible) begin
                  active_id      <= winner;
                  irq.irq_addr_o <= vec_base + {25'b0, winner, 2'b00};
                  counter        <= '0;
                  irq.irq_req_o  <= 1'b1;
                  state          <= REQ;
               end
            end
            REQ: begin
               if (irq.irq_grant_i) begin
                  irq.irq_req_o <= 1'b0;
                  state         <= SERVICE;
               end else if (counter == CNT_W'(GRANT_TIMEOUT - 1)) begin
                  irq.irq_req_o <= 1'b0;
                  timeout_flag  <= 1'b1;
                  state         <= IDLE;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            SERVICE: begin
               irq.irq_req_o <= 1'b0;
               if (irq.irq_done_i)
                  state <= IDLE;
            end
            default: begin
               irq.irq_req_o <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_source_controller.sv
// Randomized and directed bench for irq_source_controller against a cycle-level reference model.
module tb_irq_source_controller;
   localparam int unsigned N  = 8;
   localparam int unsigned T  = 64;
   localparam logic [31:0] VB = 32'h0000_0100;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  src;
   logic          cfg_we;
   logic [1:0]    cfg_addr;
   logic [31:0]   cfg_wdata;
   logic [31:0]   cfg_rdata;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   irq_source_controller_if irq_bus ();

   irq_source_controller #(.NUM_SRC(N), .VEC_BASE_RST(VB), .GRANT_TIMEOUT(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_src_i (src),
      .irq       (irq_bus),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .busy_o    (busy)
   );

   // Reference model: phase 0=idle, 1=requesting, 2=in service.
   int          m_phase, m_id, m_cnt;
   bit          m_req, m_tflag;
   bit [31:0]   m_pend, m_mask, m_prev, m_vb, m_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_id = 0; m_cnt = 0; m_req = 0; m_tflag = 0;
      m_pend = 0; m_mask = 0; m_prev = 0; m_vb = VB; m_addr = 0;
   endtask

   function automatic logic [31:0] exp_rdata(input logic [1:0] a);
      logic [1:0] ph;
      logic [4:0] id;
      ph = 2'(m_phase);
      id = 5'(m_id);
      case (a)
         2'd0:    return m_mask;
         2'd1:    return m_pend;
         2'd2:    return {ph, 21'b0, m_tflag, 3'b0, id};
         default: return m_vb;
      endcase
   endfunction

   task automatic model_step();
      bit [31:0] s, rises, clr, elig;
      s     = 32'(src);
      rises = s & ~m_prev;
      m_prev = s;
      clr = 0;
      elig = m_pend & m_mask;
      if (cfg_we && cfg_addr == 2'd1) clr = cfg_wdata & ((32'd1 << N) - 1);
      if (cfg_we && cfg_addr == 2'd2 && cfg_wdata[8]) m_tflag = 0;
      case (m_phase)
         0: if (elig != 0) begin
               for (int i = 0; i < int'(N); i++)
                  if (elig[i]) begin m_id = i; break; end
               m_addr  = m_vb + 32'(4 * m_id);
               m_cnt   = 0;
               m_req   = 1;
               m_phase = 1;
            end
         1: if (irq_bus.irq_grant_i) begin
               clr     = clr | (32'd1 << m_id);
               m_req   = 0;
               m_phase = 2;
            end else if (m_cnt == int'(T) - 1) begin
               m_req   = 0;
               m_tflag = 1;
               m_phase = 0;
            end else begin
               m_cnt++;
            end
         default: if (irq_bus.irq_done_i) m_phase = 0;
      endcase
      m_pend = (m_pend & ~clr) | rises;
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata & ((32'd1 << N) - 1);
      if (cfg_we && cfg_addr == 2'd3) m_vb = {cfg_wdata[31:2], 2'b00};
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("irq_req", 32'(irq_bus.irq_req_o), 32'(m_req));
      if (m_req) check("irq_addr", irq_bus.irq_addr_o, m_addr);
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("cfg_rdata", cfg_rdata, exp_rdata(cfg_addr));
   endtask

   task automatic quiet();
      irq_bus.irq_grant_i = 0; irq_bus.irq_done_i = 0; cfg_we = 0; cfg_wdata = 0;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 0; cfg_wdata = 0;
   endtask

   task automatic wait_req();
      int i;
      for (i = 0; i < 200; i++) begin
         if (irq_bus.irq_req_o) break;
         tick();
      end
      if (i == 200) check("wait_req_timeout", 32'(irq_bus.irq_req_o), 32'd1);
   endtask

   task automatic grant_done();
      irq_bus.irq_grant_i = 1; tick(); irq_bus.irq_grant_i = 0;
      irq_bus.irq_done_i  = 1; tick(); irq_bus.irq_done_i  = 0;
   endtask

   initial begin
      int gmode;
      reset = 1; src = 0; cfg_addr = 2'd3;
      quiet();
      model_reset();
      #12;
      check("rst_req",  32'(irq_bus.irq_req_o), 32'd0);
      check("rst_addr", irq_bus.irq_addr_o, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_vb",   cfg_rdata, 32'h100);
      @(negedge clk); reset = 0;

      // Single source 3
      cfg_write(2'd0, 32'hFF);
      cfg_addr = 2'd1;
      src = 8'h08; tick(); src = 0;
      check("s3_pending", cfg_rdata, 32'h08);
      tick();
      check("s3_req",  32'(irq_bus.irq_req_o), 32'd1);
      check("s3_addr", irq_bus.irq_addr_o, 32'h10C);
      irq_bus.irq_grant_i = 1; tick(); irq_bus.irq_grant_i = 0;
      check("s3_req_low", 32'(irq_bus.irq_req_o), 32'd0);
      check("s3_pend_clr", cfg_rdata, 32'h0);
      irq_bus.irq_done_i = 1; tick(); irq_bus.irq_done_i = 0;
      check("s3_idle", 32'(busy), 32'd0);

      // Simultaneous edges on 5 and 2
      src = 8'h24; tick(); src = 0;
      wait_req();
      check("pri_first", irq_bus.irq_addr_o, 32'h108);
      grant_done();
      wait_req();
      check("pri_second", irq_bus.irq_addr_o, 32'h114);
      grant_done();

      // Masked source then unmask
      cfg_write(2'd0, 32'h00);
      src = 8'h02; tick(); src = 0;
      tick(); tick();
      check("mask_noreq", 32'(irq_bus.irq_req_o), 32'd0);
      cfg_addr = 2'd1; tick();
      check("mask_pend", cfg_rdata, 32'h02);
      cfg_write(2'd0, 32'h02);
      wait_req();
      check("unmask_addr", irq_bus.irq_addr_o, 32'h104);
      grant_done();

      // Grant timeout
      cfg_write(2'd0, 32'hFF);
      cfg_addr = 2'd2;
      src = 8'h10; tick(); src = 0;
      wait_req();
      for (int i = 0; i < int'(T) - 1; i++) tick();
      check("to_still_req", 32'(irq_bus.irq_req_o), 32'd1);
      tick();
      check("to_drop", 32'(irq_bus.irq_req_o), 32'd0);
      check("to_flag", 32'(cfg_rdata[8]), 32'd1);
      tick();
      check("to_rereq", 32'(irq_bus.irq_req_o), 32'd1);
      check("to_rereq_addr", irq_bus.irq_addr_o, 32'h110);
      grant_done();
      cfg_write(2'd2, 32'h100);
      check("to_flag_clr", 32'(cfg_rdata[8]), 32'd0);

      // New edge on src 0 coincides with its grant
      cfg_addr = 2'd1;
      src = 8'h01; tick(); src = 0;
      wait_req();
      src = 8'h01; irq_bus.irq_grant_i = 1; tick(); irq_bus.irq_grant_i = 0; src = 0;
      check("regrant_pend", 32'(cfg_rdata[0]), 32'd1);
      irq_bus.irq_done_i = 1; tick(); irq_bus.irq_done_i = 0;
      wait_req();
      check("regrant_addr", irq_bus.irq_addr_o, 32'h100);
      grant_done();

      // Randomized traffic; gmode 0 grants eagerly, 1 sometimes starves to hit timeouts
      for (int c = 0; c < 4000; c++) begin
         gmode = (c / 500) % 2;
         quiet();
         if ($urandom_range(0, 3) == 0) src = src ^ N'(1 << $urandom_range(0, N - 1));
         if (irq_bus.irq_req_o)
            irq_bus.irq_grant_i = (gmode == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
         else
            irq_bus.irq_grant_i = ($urandom_range(0, 19) == 0);
         irq_bus.irq_done_i = ($urandom_range(0, 3) == 0);
         cfg_addr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) begin
            cfg_we = 1;
            cfg_wdata = $urandom();
            if (cfg_addr == 2'd0 && $urandom_range(0, 1) == 1) cfg_wdata = 32'hFF;
         end
         tick();
      end
      quiet(); src = 0;

      // Async reset while in SERVICE
      cfg_write(2'd0, 32'h01);
      cfg_write(2'd2, 32'h100);
      src = 8'h81; tick(); src = 0;
      wait_req();
      irq_bus.irq_grant_i = 1; tick(); irq_bus.irq_grant_i = 0;
      check("svc_busy", 32'(busy), 32'd1);
      cfg_addr = 2'd1;
      #2 reset = 1;
      #1;
      check("ar_req",  32'(irq_bus.irq_req_o), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_pend", cfg_rdata, 32'd0);
      cfg_addr = 2'd0;
      #1;
      check("ar_mask", cfg_rdata, 32'd0);
      model_reset();
      @(negedge clk); reset = 0;
      for (int i = 0; i < 5; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
